// File: rtl/cache_way_hit_select.sv
// N-way set-associative tag/valid/data store with registered hit detect,
// lowest-way priority select and word extraction from the hitting line.

module cache_way_bank #(
  parameter int TAG_BITS   = 18,
  parameter int INDEX_BITS = 8,
  parameter int SETS       = 256,
  parameter int LINE_BITS  = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic                  i_inv_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [LINE_BITS-1:0]  i_wr_line,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  input  logic [TAG_BITS-1:0]   i_rd_tag,
  output logic                  o_raw_hit,
  output logic [LINE_BITS-1:0]  o_rd_line
);
  logic [TAG_BITS-1:0]  tag_mem  [SETS];
  logic [LINE_BITS-1:0] data_mem [SETS];
  logic [SETS-1:0]      valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (i_wr_en)       valid_d[i_wr_index] = 1'b1;
    else if (i_inv_en) valid_d[i_wr_index] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  // Tag/data are not reset, but writes presented during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst && i_wr_en) begin
      tag_mem[i_wr_index]  <= i_wr_tag;
      data_mem[i_wr_index] <= i_wr_line;
    end
  end

  // Asynchronous read of the pre-write contents gives read-before-write.
  assign o_raw_hit = valid_q[i_rd_index] && (tag_mem[i_rd_index] == i_rd_tag);
  assign o_rd_line = data_mem[i_rd_index];
endmodule

module cache_way_hit_select #(
  parameter int WAYS            = 4,
  parameter int SETS            = 256,
  parameter int TAG_BITS        = 18,
  parameter int INDEX_BITS      = 8,
  parameter int OFFSET_BITS     = 6,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int DATA_WIDTH      = 32,
  localparam int LINE_BITS      = 8 * LINE_SIZE_BYTES,
  localparam int WAY_BITS       = $clog2(WAYS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_lookup,
  input  logic [TAG_BITS-1:0]    i_tag,
  input  logic [INDEX_BITS-1:0]  i_index,
  input  logic [OFFSET_BITS-1:0] i_offset,
  input  logic                   i_fill_en,
  input  logic [INDEX_BITS-1:0]  i_fill_index,
  input  logic [WAY_BITS-1:0]    i_fill_way,
  input  logic [TAG_BITS-1:0]    i_fill_tag,
  input  logic [LINE_BITS-1:0]   i_fill_line,
  input  logic                   i_inval_en,
  output logic                   o_valid,
  output logic                   o_hit,
  output logic [WAYS-1:0]        o_hit_way,
  output logic [WAY_BITS-1:0]    o_hit_idx,
  output logic                   o_multi_hit,
  output logic [DATA_WIDTH-1:0]  o_data
);
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  logic [WAYS-1:0]                raw_hit;
  logic [WAYS-1:0][LINE_BITS-1:0] rd_line;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_bank #(
      .TAG_BITS  (TAG_BITS),
      .INDEX_BITS(INDEX_BITS),
      .SETS      (SETS),
      .LINE_BITS (LINE_BITS)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (i_fill_en && (i_fill_way == WAY_BITS'(w))),
      .i_inv_en  (i_inval_en && (i_fill_way == WAY_BITS'(w))),
      .i_wr_index(i_fill_index),
      .i_wr_tag  (i_fill_tag),
      .i_wr_line (i_fill_line),
      .i_rd_index(i_index),
      .i_rd_tag  (i_tag),
      .o_raw_hit (raw_hit[w]),
      .o_rd_line (rd_line[w])
    );
  end

  logic                   valid_d, valid_q;
  logic                   hit_d, hit_q;
  logic [WAYS-1:0]        hit_way_d, hit_way_q;
  logic [WAY_BITS-1:0]    hit_idx_d, hit_idx_q;
  logic                   multi_d, multi_q;
  logic [DATA_WIDTH-1:0]  data_d, data_q;
  logic [WAY_BITS-1:0]    sel_idx;
  logic [OFFSET_BITS-1:0] word_idx;
  logic [LINE_BITS-1:0]   sel_line;

  always_comb begin
    valid_d   = i_lookup;
    hit_d     = 1'b0;
    hit_way_d = '0;
    hit_idx_d = '0;
    multi_d   = 1'b0;
    data_d    = '0;
    sel_idx   = '0;
    sel_line  = '0;
    word_idx  = i_offset >> BYTE_SHIFT;
    // Scan downward so the lowest-numbered matching way is left selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (raw_hit[w]) sel_idx = WAY_BITS'(w);
    end
    if (i_lookup && (|raw_hit)) begin
      sel_line  = rd_line[sel_idx];
      hit_d     = 1'b1;
      hit_idx_d = sel_idx;
      hit_way_d = WAYS'(1) << sel_idx;
      multi_d   = (raw_hit & (raw_hit - WAYS'(1))) != '0;
      data_d    = sel_line[word_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
      hit_idx_q <= '0;
      multi_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      hit_q     <= hit_d;
      hit_way_q <= hit_way_d;
      hit_idx_q <= hit_idx_d;
      multi_q   <= multi_d;
      data_q    <= data_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_hit       = hit_q;
  assign o_hit_way   = hit_way_q;
  assign o_hit_idx   = hit_idx_q;
  assign o_multi_hit = multi_q;
  assign o_data      = data_q;
endmodule

// File: tb/tb_cache_way_hit_select.sv
// Scoreboard bench for cache_way_hit_select: a set/way array model predicts
// each lookup response; a negedge monitor pops and compares.

module tb_cache_way_hit_select;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_lookup;
  logic [17:0]  i_tag;
  logic [7:0]   i_index;
  logic [5:0]   i_offset;
  logic         i_fill_en;
  logic [7:0]   i_fill_index;
  logic [1:0]   i_fill_way;
  logic [17:0]  i_fill_tag;
  logic [511:0] i_fill_line;
  logic         i_inval_en;
  logic         o_valid, o_hit, o_multi_hit;
  logic [3:0]   o_hit_way;
  logic [1:0]   o_hit_idx;
  logic [31:0]  o_data;

  cache_way_hit_select dut (
    .clk(clk), .rst(rst), .i_lookup(i_lookup), .i_tag(i_tag), .i_index(i_index),
    .i_offset(i_offset), .i_fill_en(i_fill_en), .i_fill_index(i_fill_index),
    .i_fill_way(i_fill_way), .i_fill_tag(i_fill_tag), .i_fill_line(i_fill_line),
    .i_inval_en(i_inval_en), .o_valid(o_valid), .o_hit(o_hit), .o_hit_way(o_hit_way),
    .o_hit_idx(o_hit_idx), .o_multi_hit(o_multi_hit), .o_data(o_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [3:0]  way;
    logic [1:0]  idx;
    logic        multi;
    logic [31:0] data;
  } exp_t;

  exp_t         sb[$];
  logic [17:0]  m_tag  [256][4];
  logic [511:0] m_line [256][4];
  bit           m_valid[256][4];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] make_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + k;
    return l;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // One clock of stimulus: predict from pre-edge model state, then commit writes.
  task automatic step(input bit r, input bit lk, input logic [17:0] tg, input logic [7:0] ix,
                      input logic [5:0] off, input bit fe, input logic [7:0] fix,
                      input logic [1:0] fw, input logic [17:0] ft, input logic [511:0] fl,
                      input bit ie);
    exp_t e;
    int   nmatch;
    logic [511:0] sh;
    rst = r; i_lookup = lk; i_tag = tg; i_index = ix; i_offset = off;
    i_fill_en = fe; i_fill_index = fix; i_fill_way = fw; i_fill_tag = ft;
    i_fill_line = fl; i_inval_en = ie;
    e = '{hit: 1'b0, way: 4'd0, idx: 2'd0, multi: 1'b0, data: 32'd0};
    nmatch = 0;
    for (int w = 0; w < 4; w++) begin
      if (m_valid[ix][w] && m_tag[ix][w] == tg) begin
        if (nmatch == 0) begin
          e.hit  = 1'b1;
          e.idx  = 2'(w);
          e.way  = 4'(1 << w);
          sh     = m_line[ix][w] >> ((off / 4) * 32);
          e.data = sh[31:0];
        end
        nmatch++;
      end
    end
    e.multi = (nmatch > 1);
    @(posedge clk);
    if (!r) begin
      for (int s = 0; s < 256; s++) for (int w = 0; w < 4; w++) m_valid[s][w] = 0;
    end else begin
      if (lk) sb.push_back(e);
      if (fe) begin
        m_valid[fix][fw] = 1; m_tag[fix][fw] = ft; m_line[fix][fw] = fl;
      end else if (ie) begin
        m_valid[fix][fw] = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0);
  endtask
  task automatic lookup(input logic [17:0] tg, input logic [7:0] ix, input logic [5:0] off);
    step(1, 1, tg, ix, off, 0, 0, 0, 0, '0, 0);
  endtask
  task automatic fill(input logic [7:0] ix, input logic [1:0] w, input logic [17:0] tg,
                      input logic [511:0] l);
    step(1, 0, 0, 0, 0, 1, ix, w, tg, l, 0);
  endtask

  // Monitor: compare each valid response; outputs must be all-zero otherwise.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (o_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 64'(o_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("hit",       64'(o_hit),       64'(e.hit));
          chk("hit_way",   64'(o_hit_way),   64'(e.way));
          chk("hit_idx",   64'(o_hit_idx),   64'(e.idx));
          chk("multi_hit", 64'(o_multi_hit), 64'(e.multi));
          chk("data",      64'(o_data),      64'(e.data));
        end
      end else begin
        chk("idle_zero", {26'd0, o_hit, o_hit_way, o_hit_idx, o_multi_hit, o_data}, 64'd0);
      end
    end
  end

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0);
    step(0, 1, 18'h1234, 8'h05, 0, 0, 0, 0, 0, '0, 0);
    lookup(18'h1234, 8'h05, 6'h00);
    @(negedge clk);
    chk("first_lookup_miss", {o_valid, o_hit, o_data}, {1'b1, 1'b0, 32'd0});

    fill(8'h05, 2'd2, 18'h1234, make_line(32'hA000_0000));
    lookup(18'h1234, 8'h05, 6'h08);
    @(negedge clk);
    chk("dir_data", 64'(o_data), 64'h0000_0000_A000_0002);
    chk("dir_way", {o_hit, o_hit_way, o_hit_idx}, {1'b1, 4'b0100, 2'd2});
    lookup(18'h1235, 8'h05, 6'h08);
    lookup(18'h1234, 8'h05, 6'h0B);
    @(negedge clk);
    chk("low_off_ignored", 64'(o_data), 64'h0000_0000_A000_0002);

    fill(8'h10, 2'd3, 18'h0777, make_line(32'hB000_0000));
    fill(8'h10, 2'd1, 18'h0777, make_line(32'hC000_0000));
    lookup(18'h0777, 8'h10, 6'h3C);
    @(negedge clk);
    chk("multi_dir", {o_hit_way, o_hit_idx, o_multi_hit}, {4'b0010, 2'd1, 1'b1});
    chk("multi_data", 64'(o_data), 64'h0000_0000_C000_000F);

    // Fill and lookup to the same set together: lookup sees old contents.
    step(1, 1, 18'h0AAA, 8'h20, 6'h04, 1, 8'h20, 2'd0, 18'h0AAA, make_line(32'hD000_0000), 0);
    lookup(18'h0AAA, 8'h20, 6'h04);
    // Fill and invalidate together: fill wins.
    step(1, 0, 0, 0, 0, 1, 8'h20, 2'd1, 18'h0BBB, make_line(32'hE000_0000), 1);
    lookup(18'h0BBB, 8'h20, 6'h00);
    step(1, 0, 0, 0, 0, 0, 8'h20, 2'd0, 0, '0, 1);
    lookup(18'h0AAA, 8'h20, 6'h04);
    lookup(18'h0BBB, 8'h20, 6'h00);
    idle();

    for (int i = 0; i < 1500; i++) begin
      bit r;
      r = (i % 500 == 250) ? 1'b0 : ($urandom_range(0, 199) != 0);
      step(r, $urandom_range(0, 1) == 1, 18'h1230 + 18'($urandom_range(0, 2)),
           8'($urandom_range(0, 3)), 6'($urandom), $urandom_range(0, 9) < 3,
           8'($urandom_range(0, 3)), 2'($urandom), 18'h1230 + 18'($urandom_range(0, 2)),
           rand_line(), $urandom_range(0, 6) == 0);
    end

    // Reset mid-stream after fills: lookups during reset are dropped, then miss.
    fill(8'h05, 2'd0, 18'h1234, make_line(32'h5000_0000));
    step(0, 1, 18'h1234, 8'h05, 6'h00, 1, 8'h06, 2'd0, 18'h1234, make_line(0), 0);
    step(0, 1, 18'h1234, 8'h05, 6'h00, 0, 0, 0, 0, '0, 0);
    lookup(18'h1234, 8'h05, 6'h00);
    lookup(18'h1234, 8'h06, 6'h00);
    lookup(18'h0777, 8'h10, 6'h00);
    idle();
    idle();
    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
